// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped write-back write-allocate data cache with a line-wide memory handshake
module dcache_controller #(
    parameter int LINE_SIZE = 16,
    parameter int NUM_SETS  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   is_input_valid,
    input  logic [31:0]            addr,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [31:0]            din,
    output logic                   is_ready,
    output logic                   is_output_valid,
    output logic [31:0]            dout,
    output logic                   is_hit,
    output logic                   mem_req_valid,
    output logic                   mem_req_rw,
    output logic [31:0]            mem_req_addr,
    output logic [LINE_SIZE*8-1:0] mem_req_wdata,
    input  logic                   mem_req_ready,
    input  logic                   mem_resp_valid,
    input  logic [LINE_SIZE*8-1:0] mem_resp_rdata
);
    localparam int OW = $clog2(LINE_SIZE);
    localparam int IW = $clog2(NUM_SETS);
    localparam int TW = 32 - OW - IW;
    localparam int LW = LINE_SIZE * 8;

    typedef enum logic [2:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE, WAIT_FILL} state_t;

    state_t              state, next_state;
    logic [NUM_SETS-1:0] valid, dirty;
    logic [TW-1:0]       tags  [NUM_SETS];
    logic [LW-1:0]       lines [NUM_SETS];
    logic [31:2]         req_addr;
    logic [31:0]         req_din;
    logic                req_store, missed;
    logic [IW-1:0]       idx;
    logic [TW-1:0]       tag;
    logic [OW-3:0]       off;
    logic                hit, accept, store_hit, fill;
    logic                unused_ok;

    assign idx       = req_addr[OW+IW-1:OW];
    assign tag       = req_addr[31:OW+IW];
    assign off       = req_addr[OW-1:2];
    assign hit       = valid[idx] && tags[idx] == tag;
    assign is_ready  = state == IDLE;
    assign accept    = is_ready && is_input_valid && (mem_read || mem_write);
    assign store_hit = state == COMPARE && hit && req_store;
    assign fill      = state == WAIT_FILL && mem_resp_valid;
    assign unused_ok = ^addr[1:0];

    // state register plus per-line valid/dirty bits and the miss marker for the current request
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            valid  <= '0;
            dirty  <= '0;
            missed <= 1'b0;
        end else begin
            state <= next_state;
            if (accept)
                missed <= 1'b0;
            if (state == COMPARE && !hit)
                missed <= 1'b1;
            if (store_hit)
                dirty[idx] <= 1'b1;
            if (fill) begin
                valid[idx] <= 1'b1;
                dirty[idx] <= 1'b0;
            end
        end
    end

    // request latch and line/tag storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (accept) begin
            req_addr  <= addr[31:2];
            req_din   <= din;
            req_store <= mem_write;
        end
        if (store_hit)
            lines[idx][{off, 5'b0} +: 32] <= req_din;
        if (fill) begin
            lines[idx] <= mem_resp_rdata;
            tags[idx]  <= tag;
        end
    end

    // next-state and output decode; memory request fields stay constant while a state waits for ready
    always_comb begin
        next_state      = state;
        is_output_valid = 1'b0;
        dout            = '0;
        is_hit          = 1'b0;
        mem_req_valid   = 1'b0;
        mem_req_rw      = 1'b0;
        mem_req_addr    = '0;
        mem_req_wdata   = '0;
        case (state)
            IDLE: next_state = accept ? COMPARE : IDLE;
            COMPARE: begin
                if (hit) begin
                    is_output_valid = 1'b1;
                    dout            = req_store ? 32'h0 : lines[idx][{off, 5'b0} +: 32];
                    is_hit          = !missed;
                    next_state      = IDLE;
                end else begin
                    next_state = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                mem_req_valid = 1'b1;
                mem_req_rw    = 1'b1;
                mem_req_addr  = {tags[idx], idx, {OW{1'b0}}};
                mem_req_wdata = lines[idx];
                next_state    = mem_req_ready ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag, idx, {OW{1'b0}}};
                next_state    = mem_req_ready ? WAIT_FILL : ALLOCATE;
            end
            WAIT_FILL: next_state = mem_resp_valid ? COMPARE : WAIT_FILL;
            default: next_state = IDLE;
        endcase
    end
endmodule
